// File: rtl/seq_pkg.sv
// Shared types and constants for the serial sequence generator/detector path.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } gen_state_t;

  // Default pattern shared by the detectors and the generator.
  localparam logic [2:0] SEQ_PATTERN = 3'b001;

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, serial-out shift register; presents the MSB on q and shifts left.
module piso_shift #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q
);

  logic [WIDTH-1:0] sr_p0;

  // Data is not cleared; clr only freezes it so a reset cycle cannot disturb the contents.
  always_ff @(posedge clk) begin
    if (!clr) begin
      if (load) begin
        sr_p0 <= d;
      end else if (shift) begin
        sr_p0 <= sr_p0 << 1;
      end
    end
  end

  assign q = sr_p0[WIDTH-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: sends a stored pattern MSB first, reps times,
// with GAP_LEN idle cycles between repetitions.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int               WIDTH    = 3,
  parameter logic [WIDTH-1:0] PATTERN  = SEQ_PATTERN,
  parameter int               CNT_W    = 4,
  parameter int               GAP_LEN  = 0,
  parameter logic             IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pat_load,
  input  logic [WIDTH-1:0] pat_in,
  input  logic             start,
  input  logic [CNT_W-1:0] reps,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  gen_state_t       state;
  logic [WIDTH-1:0] pat_reg;
  logic [BIT_W-1:0] bitcnt;
  logic [CNT_W-1:0] repcnt;
  logic [GAP_W-1:0] gapcnt;

  logic             accept;
  logic             rep_end;
  logic             more_reps;
  logic             sh_load;
  logic             sh_shift;
  logic [WIDTH-1:0] sh_d;
  logic             sh_q;

  assign accept    = (state == IDLE) && start && (reps != '0);
  assign rep_end   = (state == SHIFT) && (bitcnt == BIT_LAST);
  // repcnt still counts the repetition now finishing, so another follows when it exceeds 1.
  assign more_reps = (repcnt > CNT_W'(1));

  assign sh_load  = accept
                  || (rep_end && more_reps && (GAP_LEN == 0))
                  || ((state == GAP) && (gapcnt == GAP_LAST));
  assign sh_shift = (state == SHIFT);
  // A load coinciding with start must be the pattern that goes out.
  assign sh_d     = ((state == IDLE) && pat_load) ? pat_in : pat_reg;

  piso_shift #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk   (clk),
    .clr   (clr),
    .load  (sh_load),
    .shift (sh_shift),
    .d     (sh_d),
    .q     (sh_q)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      pat_reg <= PATTERN;
    end else if ((state == IDLE) && pat_load) begin
      pat_reg <= pat_in;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      bitcnt <= '0;
      repcnt <= '0;
      gapcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (reps != '0) begin
              state  <= SHIFT;
              bitcnt <= '0;
              repcnt <= reps;
            end else begin
              state <= DONE;
            end
          end
        end
        SHIFT: begin
          if (bitcnt == BIT_LAST) begin
            bitcnt <= '0;
            if (repcnt != '0) begin
              repcnt <= repcnt - 1'b1;
            end
            if (more_reps) begin
              if (GAP_LEN > 0) begin
                state  <= GAP;
                gapcnt <= '0;
              end
            end else begin
              state <= DONE;
            end
          end else begin
            bitcnt <= bitcnt + 1'b1;
          end
        end
        GAP: begin
          if (gapcnt == GAP_LAST) begin
            state <= SHIFT;
          end else begin
            gapcnt <= gapcnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign out   = (state == SHIFT) ? sh_q : IDLE_BIT;
  assign valid = (state == SHIFT);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: back-to-back and gapped instances against a queue-based model.
module tb_seq_pattern_gen;

  localparam int WIDTH = 3;
  localparam int CNT_W = 4;

  typedef logic [3:0] obs_t;        // {out, valid, busy, done}
  typedef obs_t obs_q_t[$];
  localparam obs_t IDLE_OBS = 4'b1000;

  logic             clk = 1'b0;
  logic             clr = 1'b1;
  logic             pat_load = 1'b0;
  logic [WIDTH-1:0] pat_in = '0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] reps = '0;

  logic out0, valid0, busy0, done0;
  logic out2, valid2, busy2, done2;

  always #5 clk = ~clk;

  seq_pattern_gen #(
    .WIDTH(WIDTH), .PATTERN(3'b001), .CNT_W(CNT_W), .GAP_LEN(0), .IDLE_BIT(1'b1)
  ) dut0 (
    .clk(clk), .clr(clr), .pat_load(pat_load), .pat_in(pat_in), .start(start),
    .reps(reps), .out(out0), .valid(valid0), .busy(busy0), .done(done0)
  );

  seq_pattern_gen #(
    .WIDTH(WIDTH), .PATTERN(3'b001), .CNT_W(CNT_W), .GAP_LEN(2), .IDLE_BIT(1'b1)
  ) dut2 (
    .clk(clk), .clr(clr), .pat_load(pat_load), .pat_in(pat_in), .start(start),
    .reps(reps), .out(out2), .valid(valid2), .busy(busy2), .done(done2)
  );

  int checks = 0;
  int errors = 0;

  obs_q_t           q0, q2;
  obs_t             cur0 = IDLE_OBS;
  obs_t             cur2 = IDLE_OBS;
  logic [WIDTH-1:0] pat0 = 3'b001;
  logic [WIDTH-1:0] pat2 = 3'b001;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole transmission as seen on the outputs, one entry per busy cycle.
  function automatic obs_q_t run_seq(input logic [WIDTH-1:0] pat, input int n, input int gap);
    obs_q_t s;
    for (int r = 0; r < n; r++) begin
      for (int b = WIDTH - 1; b >= 0; b--) s.push_back({pat[b], 1'b1, 1'b1, 1'b0});
      if (r < n - 1)
        for (int g = 0; g < gap; g++) s.push_back(4'b1010);
    end
    s.push_back(4'b1011);
    return s;
  endfunction

  task automatic step(input logic c, input logic pl, input logic [WIDTH-1:0] pi,
                      input logic st, input logic [CNT_W-1:0] rp);
    @(negedge clk);
    clr = c; pat_load = pl; pat_in = pi; start = st; reps = rp;
    if (c) begin
      q0.delete(); q2.delete();
      pat0 = 3'b001; pat2 = 3'b001;
    end else begin
      if (!cur0[1]) begin
        if (pl) pat0 = pi;
        if (st) q0 = run_seq(pat0, int'(rp), 0);
      end
      if (!cur2[1]) begin
        if (pl) pat2 = pi;
        if (st) q2 = run_seq(pat2, int'(rp), 2);
      end
    end
    cur0 = (q0.size() > 0) ? q0.pop_front() : IDLE_OBS;
    cur2 = (q2.size() > 0) ? q2.pop_front() : IDLE_OBS;
    @(posedge clk);
    #1;
    check_eq("gap0", {28'd0, out0, valid0, busy0, done0}, {28'd0, cur0});
    check_eq("gap2", {28'd0, out2, valid2, busy2, done2}, {28'd0, cur2});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'b000, 1'b0, 4'd0);
  endtask

  initial begin
    // Reset for two cycles.
    step(1'b1, 1'b0, 3'b000, 1'b0, 4'd0);
    step(1'b1, 1'b0, 3'b000, 1'b0, 4'd0);
    check_eq("rst_out", {31'd0, out0}, 32'd1);
    check_eq("rst_busy", {31'd0, busy2}, 32'd0);
    idle(2);

    // Default pattern, one and two repetitions.
    step(1'b0, 1'b0, 3'b000, 1'b1, 4'd1);
    idle(5);
    step(1'b0, 1'b0, 3'b000, 1'b1, 4'd2);
    idle(11);

    // Load with start in the same cycle, then a load attempt mid-transmission.
    step(1'b0, 1'b1, 3'b110, 1'b1, 4'd1);
    step(1'b0, 1'b1, 3'b010, 1'b0, 4'd0);
    idle(4);
    step(1'b0, 1'b0, 3'b000, 1'b1, 4'd1);
    idle(5);

    // Zero repetitions.
    step(1'b0, 1'b0, 3'b000, 1'b1, 4'd0);
    idle(3);

    // Abort by reset during bit 2.
    step(1'b0, 1'b0, 3'b000, 1'b1, 4'd3);
    step(1'b0, 1'b0, 3'b000, 1'b0, 4'd0);
    step(1'b1, 1'b0, 3'b000, 1'b0, 4'd0);
    idle(3);

    // Restart attempt while busy, then a maximum-length run.
    step(1'b0, 1'b0, 3'b000, 1'b1, 4'd2);
    step(1'b0, 1'b1, 3'b111, 1'b1, 4'd5);
    step(1'b0, 1'b0, 3'b000, 1'b1, 4'd1);
    idle(12);
    step(1'b0, 1'b1, 3'b101, 1'b1, 4'd15);
    idle(80);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic             c, pl, st;
      logic [WIDTH-1:0] pi;
      logic [CNT_W-1:0] rp;
      c  = ($urandom_range(0, 59) == 0);
      pl = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 3) == 0);
      pi = WIDTH'($urandom);
      rp = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 3));
      step(c, pl, pi, st, rp);
    end
    idle(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
